cpu_param: RTL

CPU_PARAM -- requirements
Module: cpu_param

---
 rtl/cpu_param_pkg.sv | 39 +++
 rtl/cpu_param_alu.sv | 31 +++
 rtl/cpu_param.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_param_pkg.sv
// Shared constants for the cpu_param core: stage encoding,
// opcode classes and instruction field positions.
package cpu_param_pkg;

    typedef enum logic [4:0] {
        S_AWAIT  = 5'b00001,
        S_FETCHA = 5'b00010,
        S_FETCHB = 5'b00100,
        S_EXECA  = 5'b01000,
        S_EXECB  = 5'b10000
    } stage_t;

    localparam int OPC_W  = 8;
    localparam int FLD_W  = 3;
    localparam int A_OFS  = 1;
    localparam int B_OFS  = 4;

    localparam logic [4:0] CL_MOV = 5'b00001;
    localparam logic [4:0] CL_LDI = 5'b01010;
    localparam logic [4:0] CL_LD  = 5'b01000;
    localparam logic [4:0] CL_LDS = 5'b01001;
    localparam logic [4:0] CL_ST  = 5'b01100;
    localparam logic [4:0] CL_STS = 5'b01101;
    localparam logic [4:0] CL_INC = 5'b10000;
    localparam logic [4:0] CL_DEC = 5'b10001;
    localparam logic [4:0] CL_ADD = 5'b10010;
    localparam logic [4:0] CL_SUB = 5'b10011;

    localparam logic [7:0] OP_HLT = 8'h00;
    localparam logic [7:0] OP_JC  = 8'h3D;
    localparam logic [7:0] OP_JZ  = 8'h3E;
    localparam logic [7:0] OP_JMP = 8'h3F;

    // INC/DEC/ADD/SUB share the top three class bits; the low two pick the op
    function automatic logic is_alu(input logic [4:0] cls);
        return cls[4:2] == 3'b100;
    endfunction

endpackage

// File: rtl/cpu_param_alu.sv
// Four-function ALU; ctrl: 00 inc, 01 dec, 10 add, 11 sub.
module alu_param #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        ctrl,
    output logic [DATA_W-1:0] sout,
    output logic              cout,
    output logic              zout
);

    localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

    logic [DATA_W:0] r;

    // The extra top bit is carry for inc/add and borrow for dec/sub
    always_comb begin
        unique case (ctrl)
            2'b00:   r = {1'b0, a} + ONE;
            2'b01:   r = {1'b0, a} - ONE;
            2'b10:   r = {1'b0, a} + {1'b0, b};
            default: r = {1'b0, a} - {1'b0, b};
        endcase
    end

    assign sout = r[DATA_W-1:0];
    assign cout = r[DATA_W];
    assign zout = (sout == '0);

endmodule

// File: rtl/cpu_param.sv
// Multi-cycle accumulator-less CPU: two fetch stages, two execute
// stages, eight-entry register file and a ready-throttled memory port.
module cpu_param
    import cpu_param_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              halt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              await,
    output logic              fetcha,
    output logic              fetchb,
    output logic              execa,
    output logic              execb,
    output logic              zflag,
    output logic              cflag,
    output logic [DATA_W-1:0] reg_aout,
    output logic [DATA_W-1:0] reg_bout
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    stage_t st, st_nx;

    logic [ADDR_W-1:0] pc_q;
    logic [OPC_W-1:0]  opc;
    logic [DATA_W-1:0] opd;
    logic [DATA_W-1:0] rf [0:7];
    logic              zf, cf, hpend;

    logic [4:0]        cls;
    logic [2:0]        fa, fb, fc;
    logic [ADDR_W-1:0] faddr;
    logic [DATA_W-1:0] ra, rb;
    logic              stall, take_j;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] alu_s;
    logic              alu_c, alu_z;

    assign cls   = opc[7:3];
    assign fc    = opc[2:0];
    assign fa    = opd[DATA_W-A_OFS -: FLD_W];
    assign fb    = opd[DATA_W-B_OFS -: FLD_W];
    assign faddr = opd[ADDR_W-1:0];
    assign ra    = rf[fa];
    assign rb    = rf[fb];

    alu_param #(.DATA_W(DATA_W)) u_alu (
        .a    (ra),
        .b    (rb),
        .ctrl (cls[1:0]),
        .sout (alu_s),
        .cout (alu_c),
        .zout (alu_z)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= S_AWAIT;
        else     st <= st_nx;
    end

    // A stalled memory access freezes the whole machine
    assign stall = (mem_rd | mem_wr) & ~mem_ready;

    always_comb begin
        st_nx = st;
        if (!stall) begin
            unique case (st)
                S_AWAIT:  if (run) st_nx = S_FETCHA;
                S_FETCHA: st_nx = S_FETCHB;
                S_FETCHB: st_nx = S_EXECA;
                S_EXECA:  st_nx = S_EXECB;
                S_EXECB:  st_nx = (opc == OP_HLT || hpend || halt)
                                  ? S_AWAIT : S_FETCHA;
                default:  st_nx = S_AWAIT;
            endcase
        end
    end

    always_comb begin
        mem_addr  = pc_q;
        mem_wdata = ra;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        unique case (st)
            S_FETCHA, S_FETCHB: mem_rd = 1'b1;
            S_EXECA: begin
                if (cls == CL_ST) begin
                    mem_addr = rf[fc][ADDR_W-1:0];
                    mem_wr   = 1'b1;
                end else if (cls == CL_STS) begin
                    mem_addr = faddr;
                    mem_wr   = 1'b1;
                end
            end
            S_EXECB: begin
                if (cls == CL_LD) begin
                    mem_addr = ra[ADDR_W-1:0];
                    mem_rd   = 1'b1;
                end else if (cls == CL_LDS) begin
                    mem_addr = faddr;
                    mem_rd   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = ra;
        if (!stall) begin
            if (st == S_EXECA) begin
                unique case (1'b1)
                    cls == CL_MOV: rf_we = 1'b1;
                    cls == CL_LDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = opd;
                    end
                    is_alu(cls): begin
                        rf_we    = 1'b1;
                        rf_wdata = alu_s;
                    end
                    default: ;
                endcase
            end else if (st == S_EXECB &&
                         (cls == CL_LD || cls == CL_LDS)) begin
                rf_we    = 1'b1;
                rf_wdata = mem_rdata;
            end
        end
    end

    assign take_j = (opc == OP_JMP) ||
                    (opc == OP_JZ && zf) ||
                    (opc == OP_JC && cf);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= '0;
            opc   <= '0;
            opd   <= '0;
            zf    <= 1'b0;
            cf    <= 1'b0;
            hpend <= 1'b0;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            if (st == S_EXECB && !stall)
                hpend <= 1'b0;
            else if (halt && st != S_AWAIT)
                hpend <= 1'b1;
            if (rf_we) rf[fc] <= rf_wdata;
            if (!stall) begin
                unique case (st)
                    S_FETCHA: begin
                        opc  <= mem_rdata[OPC_W-1:0];
                        pc_q <= pc_q + PC_ONE;
                    end
                    S_FETCHB: begin
                        opd  <= mem_rdata;
                        pc_q <= pc_q + PC_ONE;
                    end
                    S_EXECA: begin
                        if (is_alu(cls)) begin
                            zf <= alu_z;
                            cf <= alu_c;
                        end
                        if (take_j) pc_q <= faddr;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pc       = pc_q;
    assign await    = (st == S_AWAIT);
    assign fetcha   = (st == S_FETCHA);
    assign fetchb   = (st == S_FETCHB);
    assign execa    = (st == S_EXECA);
    assign execb    = (st == S_EXECB);
    assign zflag    = zf;
    assign cflag    = cf;
    assign reg_aout = ra;
    assign reg_bout = rb;

endmodule
